// File: rtl/fp_minmax_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_minmax_scheduler                                          |
// | Description : Round-robin scheduler that shares one combinational FP       |
// |               min/max datapath between NUM_REQ requesters. It has one      |
// |               execute register stage and a 2-entry writeback FIFO that    |
// |               carries the result, tag and source index.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fp_minmax_scheduler #(
   parameter int  NUM_REQ = 4,
   parameter int  FLEN    = 34,
   parameter int  ID_W    = 3,
   localparam int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*FLEN-1:0] req_a,
   input  logic [NUM_REQ*FLEN-1:0] req_b,
   input  logic [NUM_REQ-1:0]      req_is_max,
   input  logic [NUM_REQ*ID_W-1:0] req_id,
   output logic [FLEN-1:0]         dp_a,
   output logic [FLEN-1:0]         dp_b,
   output logic                    dp_is_max,
   input  logic [FLEN-1:0]         dp_res,
   output logic                    wb_valid,
   input  logic                    wb_ready,
   output logic [FLEN-1:0]         wb_res,
   output logic [ID_W-1:0]         wb_id,
   output logic [SRC_W-1:0]        wb_src,
   output logic                    busy
);

   localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);
   localparam logic [SRC_W:0]   NUM_EXT  = (SRC_W + 1)'(NUM_REQ);

   // unpacked views of the per-requester buses
   logic [FLEN-1:0] a_arr  [NUM_REQ];
   logic [FLEN-1:0] b_arr  [NUM_REQ];
   logic [ID_W-1:0] id_arr [NUM_REQ];

   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
         assign a_arr[i]  = req_a[i*FLEN +: FLEN];
         assign b_arr[i]  = req_b[i*FLEN +: FLEN];
         assign id_arr[i] = req_id[i*ID_W +: ID_W];
      end
   endgenerate

   // execute stage
   logic             ex_valid;
   logic [FLEN-1:0]  ex_a;
   logic [FLEN-1:0]  ex_b;
   logic             ex_is_max;
   logic [ID_W-1:0]  ex_id;
   logic [SRC_W-1:0] ex_src;

   // arbitration state
   logic [SRC_W-1:0] rr_ptr;
   logic             grant_found;
   logic [SRC_W-1:0] grant_idx;
   logic [SRC_W:0]   scan;
   logic [SRC_W-1:0] scan_idx;

   // writeback FIFO storage and pointers
   logic [FLEN-1:0]  fifo_res [2];
   logic [ID_W-1:0]  fifo_id  [2];
   logic [SRC_W-1:0] fifo_src [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;

   logic pop;
   logic ex_adv;
   logic can_issue;
   logic transfer;

   assign wb_valid  = (count != 2'd0);
   assign pop       = wb_valid & wb_ready;
   assign ex_adv    = ex_valid & ((count != 2'd2) | pop);
   assign can_issue = ~ex_valid | ex_adv;
   assign transfer  = can_issue & grant_found & rst;

   assign dp_a      = ex_a;
   assign dp_b      = ex_b;
   assign dp_is_max = ex_is_max;

   assign wb_res    = fifo_res[rd_ptr];
   assign wb_id     = fifo_id[rd_ptr];
   assign wb_src    = fifo_src[rd_ptr];

   assign busy      = ex_valid | (count != 2'd0);

   // find the first valid requester starting from rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan        = '0;
      scan_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
         if (scan >= NUM_EXT) begin
            scan = scan - NUM_EXT;
         end
         scan_idx = scan[SRC_W-1:0];
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // one-hot accept for the granted requester; held low while in reset
   always_comb begin
      req_ready = '0;
      if (transfer) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // execute register and round-robin pointer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid  <= 1'b0;
         ex_a      <= '0;
         ex_b      <= '0;
         ex_is_max <= 1'b0;
         ex_id     <= '0;
         ex_src    <= '0;
         rr_ptr    <= '0;
      end else if (transfer) begin
         ex_valid  <= 1'b1;
         ex_a      <= a_arr[grant_idx];
         ex_b      <= b_arr[grant_idx];
         ex_is_max <= req_is_max[grant_idx];
         ex_id     <= id_arr[grant_idx];
         ex_src    <= grant_idx;
         rr_ptr    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end else if (ex_adv) begin
         ex_valid  <= 1'b0;
      end
   end

   // writeback FIFO: push the datapath result when execute advances, pop on handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int e = 0; e < 2; e++) begin
            fifo_res[e] <= '0;
            fifo_id[e]  <= '0;
            fifo_src[e] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (ex_adv) begin
            fifo_res[wr_ptr] <= dp_res;
            fifo_id[wr_ptr]  <= ex_id;
            fifo_src[wr_ptr] <= ex_src;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({ex_adv, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire
